// File: rtl/mips_mem_arbiter_pkg.sv
// ============================================================================
// Module : mips_mem_arbiter_pkg
// Brief  : Shared encodings and default widths for the IF/MEM memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_mem_arbiter_pkg;

  localparam int c_addr_w_default = 32;
  localparam int c_data_w_default = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mips_wait_timer.sv
// ============================================================================
// Module : mips_wait_timer
// Brief  : Loadable up-counter with a terminal flag; times stalled BUSY cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_wait_timer #(
  parameter int CNT_W = 8,
  parameter int TERM  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at the terminal value so a hung memory cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && !term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign term = (r_cnt == CNT_W'(TERM));

endmodule

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// ============================================================================
// Module : mips_mem_arbiter
// Brief  : Shares one variable-latency memory between instruction fetch and
//          load/store, with data priority, IF anti-starvation and timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = c_addr_w_default,
  parameter int DATA_W    = c_data_w_default,
  parameter int MAX_WAIT  = 15,
  parameter int IF_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  localparam int c_starve_w = 4;
  localparam int c_wait_w   = 8;

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  owner_t                  r_owner;
  owner_t                  w_grant_owner;
  logic [c_starve_w-1:0]   r_starve_cnt;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [DATA_W-1:0]       r_mem_wdata;
  logic [DATA_W-1:0]       r_if_rdata;
  logic [DATA_W-1:0]       r_dm_rdata;
  logic                    r_if_ack;
  logic                    r_dm_ack;
  logic                    r_timeout_err;
  logic                    w_dm_req;
  logic                    w_starve_hit;
  logic                    w_grant;
  logic                    w_finish;
  logic                    w_timeout;
  logic                    w_wait_term;
  logic [DATA_W-1:0]       w_rdata_cap;

  assign w_dm_req      = dm_rd | dm_wr;
  assign w_starve_hit  = if_req && (r_starve_cnt == c_starve_w'(IF_STARVE));
  assign w_grant_owner = (w_dm_req && !w_starve_hit) ? OWN_DM : OWN_IF;

  mips_wait_timer #(
    .CNT_W (c_wait_w),
    .TERM  (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_grant),
    .load_val ('0),
    .en       ((r_state == ST_BUSY) && !mem_ready),
    .term     (w_wait_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A real completion wins over a timeout that lands in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_req || w_dm_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_wait_term) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rdata_cap = (w_timeout || r_mem_we) ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= OWN_IF;
      r_starve_cnt  <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_if_ack      <= 1'b0;
      r_dm_ack      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      if (w_grant) begin
        r_owner   <= w_grant_owner;
        r_mem_req <= 1'b1;
        if (w_grant_owner == OWN_DM) begin
          r_mem_we    <= dm_wr;
          r_mem_addr  <= dm_addr;
          r_mem_wdata <= dm_wdata;
          if (if_req && (r_starve_cnt != c_starve_w'(IF_STARVE))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end else if (!if_req) begin
            r_starve_cnt <= '0;
          end
        end else begin
          r_mem_we     <= 1'b0;
          r_mem_addr   <= if_addr;
          r_mem_wdata  <= '0;
          r_starve_cnt <= '0;
        end
      end
      if (w_finish) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_owner == OWN_DM) begin
          r_dm_ack   <= 1'b1;
          r_dm_rdata <= w_rdata_cap;
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_rdata_cap;
        end
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;
  assign if_ack      = r_if_ack;
  assign dm_ack      = r_dm_ack;
  assign timeout_err = r_timeout_err;
  assign stall_if    = if_req & ~r_if_ack;
  assign stall_mem   = w_dm_req & ~r_dm_ack;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ============================================================================
// Module : tb_mips_mem_arbiter
// Brief  : Self-checking bench for mips_mem_arbiter (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 15;
  localparam int IF_STARVE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              timeout_err;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WAIT  (MAX_WAIT),
    .IF_STARVE (IF_STARVE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .dm_rd       (dm_rd),
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        own;      // 0 = fetch, 1 = data
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;      // stalled BUSY cycles before mem_ready
    logic [31:0] mrdata;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic drive_req(input logic own, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (!own) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dm_rd = rd; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
    end
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("mem_req_seen", 32'd0, 32'd1);
  endtask

  task automatic check_issue();
    exp_t e = sb[0];
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    chk("mem_addr", mem_addr, e.addr);
    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
    if (e.own) chk("stall_mem", {31'd0, stall_mem}, 32'd1);
    else       chk("stall_if", {31'd0, stall_if}, 32'd1);
  endtask

  // Requester inputs are scrambled while stalled; the latched copy must hold.
  task automatic serve(input int lat, input logic [31:0] data);
    exp_t e = sb[0];
    for (int i = 0; i < lat; i++) begin
      mem_ready = 1'b0;
      if_addr  = if_addr ^ 32'hFFFF_0000;
      dm_addr  = dm_addr ^ 32'hFFFF_0000;
      dm_wdata = dm_wdata ^ 32'h0F0F_0F0F;
      @(negedge clk);
      chk("addr_hold", mem_addr, e.addr);
      if (e.we) chk("wdata_hold", mem_wdata, e.wdata);
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
  endtask

  task automatic wait_ack(output int waited);
    exp_t e;
    waited = 0;
    while (!(if_ack || dm_ack) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    e = sb.pop_front();
    if (!(if_ack || dm_ack)) begin
      chk("ack_seen", 32'd0, 32'd1);
    end else begin
      chk("ack_owner", {30'd0, dm_ack, if_ack}, e.own ? 32'd2 : 32'd1);
      chk("rdata", e.own ? dm_rdata : if_rdata, e.rdata);
    end
  endtask

  task automatic push_exp(input logic own, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.own = own; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int waited;
    push_exp(v.own, v.exp_we, v.addr, v.wdata, v.exp_rdata);
    drive_req(v.own, v.rd, v.wr, v.addr, v.wdata);
    wait_mem_req(ok);
    if (ok) begin
      check_issue();
      serve(v.lat, v.mrdata);
      wait_ack(waited);
      chk("ack_latency", waited, 32'd0);
    end else begin
      void'(sb.pop_front());
    end
    clear_req();
    @(negedge clk);
    chk("ack_pulse_width", {30'd0, if_ack, dm_ack}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int waited;
    int n;
    logic exp_own;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h8C22_0004, 1'b0, 32'h8C22_0004};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 32'h1234_5678, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 2, 32'h7777_7777, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0404, 32'h0, 5, 32'h0123_4567, 1'b0, 32'h0123_4567};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};

    rst_n = 1'b0;
    clear_req();
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: data wins IF_STARVE times, then fetch is forced through.
    if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_rd  = 1'b1; dm_addr = 32'h0000_2000;
    for (int k = 0; k < 10; k++) begin
      exp_own = ((k % (IF_STARVE + 1)) == IF_STARVE) ? 1'b0 : 1'b1;
      push_exp(exp_own, 1'b0, exp_own ? 32'h0000_2000 : 32'h0000_1000, 32'h0, 32'h100 + k);
      wait_mem_req(ok);
      if (!ok) begin
        void'(sb.pop_front());
        break;
      end
      check_issue();
      serve(0, 32'h100 + k);
      wait_ack(waited);
    end
    clear_req();
    repeat (2) @(negedge clk);

    // Hung memory: timeout aborts the access with zero data.
    push_exp(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    wait_mem_req(ok);
    if (ok) begin
      check_issue();
      n = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (if_ack || dm_ack) break;
        if (mem_req) n++;
      end
      checks++;
      if (n < MAX_WAIT || n > MAX_WAIT + 1) begin
        errors++;
        $display("FAIL timeout_cycles: got %0d busy cycles expected %0d..%0d", n, MAX_WAIT, MAX_WAIT + 1);
      end
      wait_ack(waited);
      chk("timeout_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      void'(sb.pop_front());
    end
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    clear_req();
    @(negedge clk);
    run_vec(vecs[0]);
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Stray mem_ready while idle must be ignored.
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ready_no_req", {31'd0, mem_req}, 32'd0);
      chk("stray_ready_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
    end
    mem_ready = 1'b0;
    run_vec(vecs[5]);

    // Asynchronous reset mid-access.
    drive_req(1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0);
    wait_mem_req(ok);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, mem_req, if_ack, dm_ack}, 32'd0);
    end
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
